// File: rtl/strength_bus_resolver.sv
// Registered multi-driver bus resolver with Verilog-style strengths: per bit the
// strongest enabled driver wins, equal-strength disagreement gives X, no driver gives Z or keeper.
module strength_bus_resolver #(
    parameter int W      = 100,
    parameter int N      = 2,
    parameter int KEEPER = 0,
    parameter int CW     = 8,
    parameter int PW     = (W > 1) ? $clog2(W) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    drv_en,
    input  logic [N*W-1:0]  drv_val,
    input  logic [N*3-1:0]  drv_str,
    input  logic [PW-1:0]   probe_idx,
    input  logic            clr,
    output logic [W-1:0]    out_val,
    output logic [W-1:0]    out_z,
    output logic [W-1:0]    out_x,
    output logic            probe_bit,
    output logic            probe_x,
    output logic            conflict,
    output logic            conflict_sticky,
    output logic [CW-1:0]   conflict_cnt
);

    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    logic [2:0]    eff_str [N];
    logic [2:0]    max_str;
    logic [N-1:0]  top_mask;
    logic          undriven;

    logic [W-1:0]  val_next;
    logic [W-1:0]  z_next;
    logic [W-1:0]  x_next;
    logic [W-1:0]  probe_hit;
    logic          probe_bit_next;
    logic          probe_x_next;
    logic          conflict_next;
    logic          sticky_next;
    logic [CW-1:0] cnt_next;

    // A disabled driver is treated exactly like a highz (strength 0) driver.
    for (genvar gi = 0; gi < N; gi++) begin : g_eff
        assign eff_str[gi] = drv_en[gi] ? drv_str[gi*3 +: 3] : 3'd0;
    end

    always_comb begin
        max_str = 3'd0;
        for (int i = 0; i < N; i++) begin
            if (eff_str[i] > max_str) begin
                max_str = eff_str[i];
            end
        end
    end

    assign undriven = (max_str == 3'd0);

    // Only drivers sitting at the winning strength take part in the per-bit vote.
    for (genvar gi = 0; gi < N; gi++) begin : g_top
        assign top_mask[gi] = !undriven && (eff_str[gi] == max_str);
    end

    for (genvar gi = 0; gi < W; gi++) begin : g_bit
        logic [N-1:0] col;
        logic         has1;
        logic         has0;

        for (genvar gj = 0; gj < N; gj++) begin : g_col
            assign col[gj] = drv_val[gj*W + gi];
        end

        assign has1 = |(top_mask & col);
        assign has0 = |(top_mask & ~col);

        // The keeper feeds back the registered value, which is already 0 after an X.
        assign val_next[gi] = undriven ? ((KEEPER != 0) ? out_val[gi] : 1'b0)
                                       : (has1 && !has0);
        assign z_next[gi]   = undriven && (KEEPER == 0);
        assign x_next[gi]   = has1 && has0;

        // Out-of-range probe indices match no bit and therefore read as 0.
        assign probe_hit[gi] = (int'(probe_idx) == gi);
    end

    assign probe_bit_next = |(val_next & probe_hit);
    assign probe_x_next   = |(x_next & probe_hit);
    assign conflict_next  = |x_next;

    always_comb begin
        cnt_next    = conflict_cnt;
        sticky_next = conflict_sticky;
        if (clr) begin
            cnt_next    = '0;
            sticky_next = 1'b0;
        end else if (conflict_next) begin
            sticky_next = 1'b1;
            if (conflict_cnt != CNT_MAX) begin
                cnt_next = conflict_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_val         <= '0;
            out_z           <= {W{KEEPER == 0}};
            out_x           <= '0;
            probe_bit       <= 1'b0;
            probe_x         <= 1'b0;
            conflict        <= 1'b0;
            conflict_sticky <= 1'b0;
            conflict_cnt    <= '0;
        end else begin
            out_val         <= val_next;
            out_z           <= z_next;
            out_x           <= x_next;
            probe_bit       <= probe_bit_next;
            probe_x         <= probe_x_next;
            conflict        <= conflict_next;
            conflict_sticky <= sticky_next;
            conflict_cnt    <= cnt_next;
        end
    end

endmodule

// File: tb/tb_strength_bus_resolver.sv
// Directed bench: a 3-driver non-keeper instance checked against a scoreboard model,
// plus a small keeper instance checked against hand-computed constants.
module tb_strength_bus_resolver;

    localparam int W  = 100;
    localparam int N  = 3;
    localparam int PW = 7;
    localparam int KW = 8;
    localparam int KN = 2;
    localparam logic [99:0] ONES = {100{1'b1}};

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // main instance: KEEPER=0, CW=2
    logic [N-1:0]   drv_en;
    logic [N*W-1:0] drv_val;
    logic [N*3-1:0] drv_str;
    logic [PW-1:0]  probe_idx;
    logic           clr;
    logic [W-1:0]   out_val, out_z, out_x;
    logic           probe_bit, probe_x, conflict, conflict_sticky;
    logic [1:0]     conflict_cnt;

    // keeper instance: KEEPER=1, W=8, N=2
    logic [KN-1:0]    k_en;
    logic [KN*KW-1:0] k_val;
    logic [KN*3-1:0]  k_str;
    logic [2:0]       k_probe;
    logic [KW-1:0]    k_out_val, k_out_z, k_out_x;
    logic             k_probe_bit, k_probe_x, k_conflict, k_sticky;
    logic [7:0]       k_cnt;

    strength_bus_resolver #(.W(W), .N(N), .KEEPER(0), .CW(2), .PW(PW)) dut (
        .clk(clk), .rst(rst), .drv_en(drv_en), .drv_val(drv_val), .drv_str(drv_str),
        .probe_idx(probe_idx), .clr(clr), .out_val(out_val), .out_z(out_z), .out_x(out_x),
        .probe_bit(probe_bit), .probe_x(probe_x), .conflict(conflict),
        .conflict_sticky(conflict_sticky), .conflict_cnt(conflict_cnt)
    );

    strength_bus_resolver #(.W(KW), .N(KN), .KEEPER(1), .CW(8), .PW(3)) dutk (
        .clk(clk), .rst(rst), .drv_en(k_en), .drv_val(k_val), .drv_str(k_str),
        .probe_idx(k_probe), .clr(1'b0), .out_val(k_out_val), .out_z(k_out_z), .out_x(k_out_x),
        .probe_bit(k_probe_bit), .probe_x(k_probe_x), .conflict(k_conflict),
        .conflict_sticky(k_sticky), .conflict_cnt(k_cnt)
    );

    typedef struct {
        logic [99:0] val;
        logic [99:0] z;
        logic [99:0] x;
        logic        pb;
        logic        px;
        logic        conf;
        logic        sticky;
        logic [1:0]  cnt;
    } exp_t;

    exp_t     q[$];
    int       checks = 0;
    int       errors = 0;
    int       txn = 0;
    logic [1:0] m_cnt = 2'd0;
    logic       m_sticky = 1'b0;

    task automatic chk(input string tag, input logic [99:0] obs, input logic [99:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic set_drv(input int i, input logic e, input logic [2:0] s, input logic [99:0] v);
        drv_en[i]          = e;
        drv_str[i*3 +: 3]  = s;
        drv_val[i*W +: W]  = v;
    endtask

    function automatic logic [99:0] rand100();
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        return r[99:0];
    endfunction

    // Reference resolution of the currently driven inputs, plus counter/sticky bookkeeping.
    function automatic exp_t model(input logic c);
        exp_t e;
        logic [2:0] effs [N];
        logic [2:0] smax;
        logic h0, h1;
        smax = 3'd0;
        for (int i = 0; i < N; i++) begin
            effs[i] = drv_en[i] ? drv_str[i*3 +: 3] : 3'd0;
            if (effs[i] > smax) smax = effs[i];
        end
        e.val = '0; e.z = '0; e.x = '0;
        for (int b = 0; b < W; b++) begin
            h0 = 1'b0; h1 = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (smax != 3'd0 && effs[i] == smax) begin
                    if (drv_val[i*W + b]) h1 = 1'b1; else h0 = 1'b1;
                end
            end
            if (smax == 3'd0) e.z[b] = 1'b1;
            else if (h0 && h1) e.x[b] = 1'b1;
            else e.val[b] = h1;
        end
        e.pb = (probe_idx < 7'd100) ? e.val[probe_idx] : 1'b0;
        e.px = (probe_idx < 7'd100) ? e.x[probe_idx] : 1'b0;
        e.conf = |e.x;
        if (c) begin
            m_cnt = 2'd0;
            m_sticky = 1'b0;
        end else if (e.conf) begin
            m_sticky = 1'b1;
            if (m_cnt != 2'd3) m_cnt = m_cnt + 2'd1;
        end
        e.sticky = m_sticky;
        e.cnt = m_cnt;
        return e;
    endfunction

    task automatic step(input logic c);
        exp_t e;
        clr = c;
        q.push_back(model(c));
        @(posedge clk);
        #1;
        clr = 1'b0;
        e = q.pop_front();
        txn++;
        $display("txn %0d: val=%h x=%h z=%h probe=%b/%b conflict=%b sticky=%b cnt=%0d",
                 txn, out_val, out_x, out_z, probe_bit, probe_x, conflict, conflict_sticky, conflict_cnt);
        chk("out_val", out_val, e.val);
        chk("out_x", out_x, e.x);
        chk("out_z", out_z, e.z);
        chk("probe_bit", 100'(probe_bit), 100'(e.pb));
        chk("probe_x", 100'(probe_x), 100'(e.px));
        chk("conflict", 100'(conflict), 100'(e.conf));
        chk("sticky", 100'(conflict_sticky), 100'(e.sticky));
        chk("cnt", 100'(conflict_cnt), 100'(e.cnt));
    endtask

    task automatic chk_reset_state();
        chk("rst_val", out_val, '0);
        chk("rst_z", out_z, ONES);
        chk("rst_x", out_x, '0);
        chk("rst_probe", 100'({probe_bit, probe_x}), '0);
        chk("rst_conflict", 100'({conflict, conflict_sticky}), '0);
        chk("rst_cnt", 100'(conflict_cnt), '0);
        chk("rst_kval", 100'(k_out_val), '0);
        chk("rst_kz", 100'(k_out_z), '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; clr = 1'b0;
        drv_en = '0; drv_val = '0; drv_str = '0; probe_idx = '0;
        k_en = '0; k_val = '0; k_str = '0; k_probe = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_state();
        rst = 1'b0;

        // strongest driver overrides a weaker one
        probe_idx = 7'd50;
        set_drv(0, 1'b1, 3'd3, '0);
        set_drv(1, 1'b1, 3'd6, ONES);
        step(1'b0);
        chk("overwrite_val", out_val, ONES);
        chk("overwrite_probe", 100'(probe_bit), 100'(1));

        // equal-strength disagreement on bits 7:4
        set_drv(0, 1'b1, 3'd6, 100'h0F);
        set_drv(1, 1'b1, 3'd6, 100'hFF);
        step(1'b0);
        chk("tie_x", out_x, 100'hF0);
        chk("tie_val", out_val, 100'h0F);

        // a weaker driver agreeing with one side never breaks the tie
        set_drv(2, 1'b1, 3'd3, 100'hFF);
        step(1'b0);
        chk("weak_no_break", out_x, 100'hF0);

        // saturation of the 2-bit counter, then clr with conflict present
        repeat (3) step(1'b0);
        chk("saturated", 100'(conflict_cnt), 100'(3));
        step(1'b1);
        chk("clr_cnt", 100'(conflict_cnt), 100'(0));
        chk("clr_conflict", 100'(conflict), 100'(1));
        step(1'b0);

        // supply vs supply is X too
        set_drv(2, 1'b0, 3'd0, '0);
        set_drv(0, 1'b1, 3'd7, '0);
        set_drv(1, 1'b1, 3'd7, ONES);
        step(1'b0);

        // probe at the top bit and out of range
        set_drv(0, 1'b1, 3'd2, rand100());
        set_drv(1, 1'b1, 3'd6, rand100() | (100'd1 << 99));
        probe_idx = 7'd99;
        step(1'b0);
        probe_idx = 7'd127;
        step(1'b0);
        set_drv(0, 1'b1, 3'd6, '0);
        probe_idx = 7'd99;
        step(1'b0);
        chk("probe_x99", 100'(probe_x), 100'(1));
        probe_idx = 7'd127;
        step(1'b0);

        // undriven bus reports Z on the non-keeper instance; keeper holds on the other
        set_drv(0, 1'b1, 3'd5, 100'h5);
        set_drv(1, 1'b0, 3'd6, ONES);
        k_en = 2'b01; k_str = 6'o05; k_val = 16'h0005; k_probe = 3'd0;
        step(1'b0);
        chk("k_drive", 100'(k_out_val), 100'h05);
        drv_en = '0;
        k_en = 2'b00;
        step(1'b0);
        chk("undriven_z", out_z, ONES);
        chk("k_hold_val", 100'(k_out_val), 100'h05);
        chk("k_hold_z", 100'(k_out_z), '0);
        chk("k_probe", 100'(k_probe_bit), 100'(1));
        repeat (2) step(1'b0);
        chk("k_hold_long", 100'(k_out_val), 100'h05);
        k_en = 2'b11; k_str = 6'o66; k_val = 16'hF00F;
        step(1'b0);
        chk("k_x", 100'(k_out_x), 100'hFF);
        chk("k_x_val", 100'(k_out_val), '0);
        chk("k_conflict", 100'(k_conflict), 100'(1));
        k_en = 2'b00;
        step(1'b0);
        chk("k_after_x", 100'({k_out_x, k_out_val}), '0);

        // pseudo-random mixes of enables and strengths
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < N; i++)
                set_drv(i, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), rand100());
            probe_idx = 7'($urandom_range(0, 127));
            step(1'b0);
        end

        // build cnt=2, then reset between edges
        set_drv(0, 1'b1, 3'd4, '0);
        set_drv(1, 1'b1, 3'd1, ONES);
        set_drv(2, 1'b0, 3'd0, '0);
        step(1'b1);
        set_drv(1, 1'b1, 3'd4, ONES);
        step(1'b0);
        step(1'b0);
        chk("pre_rst_cnt", 100'(conflict_cnt), 100'(2));
        #2 rst = 1'b1;
        m_cnt = 2'd0;
        m_sticky = 1'b0;
        #1;
        chk_reset_state();
        k_en = 2'b01; k_str = 6'o01; k_val = 16'h0033;
        #1 rst = 1'b0;
        step(1'b0);
        chk("post_rst_cnt", 100'(conflict_cnt), 100'(1));
        chk("post_rst_k", 100'(k_out_val), 100'h33);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/strength_bus_resolver.md
Name: strength_bus_resolver

Overview:
- Clocked resolver for a W-bit bus driven by N drivers, each with a Verilog-style strength level.
- Per bit: the strongest active driver wins. Equal-strength disagreement resolves to X. No driver resolves to Z, or to the held value when the keeper is enabled.
- Results are registered. A single-bit probe tap, a sticky conflict flag and a saturating conflict counter are provided.
- Used as the synthesizable reference model for the multi-driver strength tests.

Parameters:
- W, 100, bus width in bits (>=1).
- N, 2, number of drivers (>=1).
- KEEPER, 0, 1 = bus keeper holds last resolved value on undriven bits; 0 = undriven bits report Z.
- CW, 8, conflict counter width.
- PW, $clog2(W) (min 1), probe index width.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- drv_en  input  N  per-driver enable; 0 means the driver is high-Z regardless of strength.
- drv_val  input  N*W  driver values, driver i at [i*W +: W].
- drv_str  input  N*3  driver strength, driver i at [i*3 +: 3].
  - Encoding: 0 highz, 1 small, 2 medium, 3 weak, 4 large, 5 pull, 6 strong, 7 supply.
- probe_idx  input  PW  bit index sampled into probe_bit.
- clr  input  1  synchronous clear of conflict_cnt and conflict_sticky.
- out_val  output  W  resolved value; 0 where out_x or out_z is set.
- out_z  output  W  bit undriven (always 0 when KEEPER=1).
- out_x  output  W  bit in conflict.
- probe_bit  output  1  resolved value of bit probe_idx.
- probe_x  output  1  conflict flag of bit probe_idx.
- conflict  output  1  OR of out_x (this registered cycle).
- conflict_sticky  output  1  set by any conflict, cleared by clr or rst.
- conflict_cnt  output  CW  count of cycles with conflict, saturating.

Behaviour:
- Reset (async assert, sync-free release):
  - out_val=0, out_x=0, probe_bit=0, probe_x=0, conflict=0, conflict_sticky=0, conflict_cnt=0.
  - out_z = all ones if KEEPER=0, else 0; with KEEPER=1 the keeper state is 0.
- Effective strength per driver: drv_en[i] ? drv_str[i] : 0. A driver with strength 0 does not participate.
- Combinational per-bit resolution, registered on the next rising clk (latency 1 cycle from input change to output):
  - S = max effective strength over all drivers.
  - S=0:
    - KEEPER=0 -> z=1, val=0, x=0.
    - KEEPER=1 -> val = current out_val bit, z=0, x=0.
  - S>0 and all drivers at strength S agree on value v -> val=v, z=0, x=0.
  - S>0 and drivers at strength S disagree -> x=1, val=0, z=0. Weaker drivers never break a tie.
  - Supply vs supply disagreement is also X.
- Keeper after X: the keeper holds 0 (the out_val encoding of X), and the bit's x clears on the next undriven cycle.
- Probe: probe_bit/probe_x are registered from the same resolution as out_*, in the same cycle. probe_idx >= W gives probe_bit=0, probe_x=0.
- conflict = OR of the next out_x, registered together with it.
- conflict_cnt:
  - Increments by 1 on each clock where the new conflict=1.
  - Saturates at 2^CW-1 and does not wrap.
- clr:
  - Has priority over increment and sticky set in the same cycle; the result is cnt=0 and sticky=0.
  - conflict itself still reflects that cycle.
- N=1: X is impossible; the block degenerates to register plus Z/keeper.
- rst asserted mid-operation clears all state immediately, with no clock needed. The first post-release edge resolves the current inputs normally.

Test Plan:
- Strength overwrite: W=100, N=2; drv0 en=1 str=3 (weak) val=0; drv1 en=1 str=6 (strong) val=all ones; probe_idx=50 -> after 1 clk: out_val=all ones, out_x=0, out_z=0, probe_bit=1, conflict=0.
- Equal-strength conflict: both str=6; drv0 val=0x0F on low byte, drv1 val=0xFF -> out_x[7:4]=1, out_val[3:0]=1, out_val[7:4]=0, conflict=1, conflict_sticky=1, cnt=1. A third weak driver (str=3) matching drv1 does not remove the X.
- Undriven, KEEPER=0: drive val=0x5 str=5 for one clk, then drv_en=0 -> out_z=all ones, out_val=0. KEEPER=1 -> out_val stays 0x5 and out_z=0 indefinitely.
- Counter saturation and clr: CW=2, continuous conflict for 5 clks -> cnt 1,2,3,3,3. Then clr=1 with conflict present -> cnt=0, sticky=0, conflict=1. Next clk with clr=0 -> cnt=1.
- Probe bounds: W=100, probe_idx=99 -> tracks out_val[99]; probe_idx=127 -> probe_bit=0, probe_x=0.
- Async reset mid-operation: assert rst between edges while cnt=2 -> all outputs reach reset values before the next edge. Release, then the next edge resolves the live inputs.
